// File: rtl/nios32_button_ctrl_if.sv
// Avalon-MM slave bundle for the push-button controller: register access plus level irq.
interface nios32_button_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios32_button_ctrl.sv
// Button debounce, rising-edge capture and maskable irq behind a 4-register Avalon-MM slave.
// Latency: pins reach DATA after 2+DEBOUNCE_CYCLES edges; reads return one cycle later; no backpressure.
// NIOS32_BUTTON_CTRL_ACTIVE_LOW_EN: invert the pins before synchronising, for active-low keys.
module nios32_button_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_port,
    nios32_button_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_nxt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] ec_clr;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [31:0]      rd_mux;
    logic             wr_en;

`ifdef NIOS32_BUTTON_CTRL_ACTIVE_LOW_EN
    assign pin = ~in_port;
`else
    assign pin = in_port;
`endif

    assign wr_en = bus.chipselect && bus.write;

    // Count consecutive edges on which the synchronised pin disagrees with the debounced state.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != deb[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    deb_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise   = deb_nxt & ~deb;
    assign ec_clr = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0: rd_mux[WIDTH-1:0] = deb;
            2'd1: rd_mux[WIDTH-1:0] = irqmask;
            2'd2: rd_mux[WIDTH-1:0] = edgecapture;
            2'd3: rd_mux[WIDTH-1:0] = s2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1           <= '0;
            s2           <= '0;
            deb          <= '0;
            irqmask      <= '0;
            edgecapture  <= '0;
            bus.readdata <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            s1  <= pin;
            s2  <= s1;
            deb <= deb_nxt;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
            if (wr_en && bus.address == 2'd1) irqmask <= bus.writedata[WIDTH-1:0];
            // A new capture on the same edge as a software clear must survive.
            edgecapture  <= (edgecapture & ~ec_clr) | rise;
            bus.readdata <= rd_mux;
        end
    end

    assign bus.irq = |(edgecapture & irqmask);

    // Write bits above WIDTH have no backing storage.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.writedata};
endmodule

// File: tb/tb_nios32_button_ctrl.sv
// Self-checking bench: directed scenarios then random pins/bus traffic against a sample-window model.
module tb_nios32_button_ctrl;
    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;
    int           checks = 0;
    int           errors = 0;

    nios32_button_ctrl_if bus_if ();

    nios32_button_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // Reference state: debounced value flips once the last DC synchronised samples all disagree with it.
    logic [W-1:0]  m_s1, m_s2, m_deb, m_mask, m_ec;
    logic [31:0]   m_rd;
    logic [W-1:0]  hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] nd;
        logic         all_diff;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_ec = '0; m_rd = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DC) void'(hist.pop_front());
            nd = m_deb;
            if (hist.size() == DC) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) nd[b] = ~m_deb[b];
                end
            end
            case (bus_if.address)
                2'd0: m_rd = 32'(m_deb);
                2'd1: m_rd = 32'(m_mask);
                2'd2: m_rd = 32'(m_ec);
                default: m_rd = 32'(m_s2);
            endcase
            if (bus_if.chipselect && bus_if.write) begin
                if (bus_if.address == 2'd1) m_mask = bus_if.writedata[W-1:0];
                if (bus_if.address == 2'd2) m_ec = m_ec & ~bus_if.writedata[W-1:0];
            end
            m_ec  = m_ec | (nd & ~m_deb);
            m_s2  = m_s1;
            m_s1  = in_port;
            m_deb = nd;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("readdata", bus_if.readdata, m_rd);
        chk("irq", 32'(bus_if.irq), 32'(|(m_ec & m_mask)));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.address = a; bus_if.chipselect = 1'b1; bus_if.write = 1'b1; bus_if.writedata = d;
        tick();
        bus_if.write = 1'b0; bus_if.chipselect = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        bus_if.address = a; bus_if.chipselect = 1'b1;
        tick();
        chk(tag, bus_if.readdata, exp);
    endtask

    initial begin
        reset = 1'b1; in_port = '0;
        bus_if.address = '0; bus_if.chipselect = 1'b0; bus_if.write = 1'b0; bus_if.writedata = '0;
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_ec = '0; m_rd = '0;
        ticks(2);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) rd(2'(a), "reset_read", 32'h0);
        chk("reset_irq", 32'(bus_if.irq), 32'h0);

        // Stable press: deb rises on the 6th edge, visible on readdata one edge later.
        bus_if.address = 2'd0;
        in_port = 4'b0001;
        ticks(6);
        chk("press_data_before", bus_if.readdata, 32'h0);
        tick();
        chk("press_data", bus_if.readdata, 32'h1);
        rd(2'd2, "press_ec", 32'h1);
        chk("press_irq_masked", 32'(bus_if.irq), 32'h0);
        wr(2'd2, 32'h1);

        // Short glitch on bit1 must not qualify; release of bit0 must not capture.
        in_port = 4'b0010;
        bus_if.address = 2'd3;
        ticks(3);
        in_port = 4'b0000;
        tick();
        chk("glitch_raw", bus_if.readdata, 32'h2);
        ticks(10);
        rd(2'd0, "glitch_data", 32'h0);
        rd(2'd2, "glitch_ec", 32'h0);

        // Interrupt enable, raise, and write-1-to-clear.
        wr(2'd1, 32'hF);
        rd(2'd1, "mask_read", 32'hF);
        in_port = 4'b0100;
        ticks(8);
        chk("irq_raise", 32'(bus_if.irq), 32'h1);
        wr(2'd2, 32'h4);
        chk("irq_clear", 32'(bus_if.irq), 32'h0);
        rd(2'd2, "ec_cleared", 32'h0);

        // Clear collides with a new capture on the same edge.
        in_port = 4'b0101;
        ticks(5);
        wr(2'd2, 32'h1);
        rd(2'd2, "set_wins", 32'h1);

        // Reset mid-count, button held across it.
        in_port = 4'b1000;
        ticks(3);
        reset = 1'b1;
        ticks(2);
        chk("reset_mid_rd", bus_if.readdata, 32'h0);
        reset = 1'b0;
        bus_if.address = 2'd0;
        ticks(6);
        chk("requal_before", bus_if.readdata, 32'h0);
        tick();
        chk("requal_data", bus_if.readdata, 32'h8);
        rd(2'd2, "requal_ec", 32'h8);

        // Random pins and bus traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            bus_if.address    = 2'($urandom);
            bus_if.chipselect = ($urandom_range(0, 3) != 0);
            bus_if.write      = ($urandom_range(0, 5) == 0);
            bus_if.writedata  = $urandom;
            tick();
        end
        reset = 1'b0; bus_if.write = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nios32_button_ctrl.md
Name: nios32_button_ctrl

Overview:
- Debounce, edge-capture and interrupt controller for the 4-bit push-button input of the nios32 system.
- Synchronises raw button pins, filters contact bounce and latches rising edges of each debounced button.
- Raises a maskable interrupt to the Nios II and exposes all state through a 2-bit-address Avalon-MM slave.
- Sits between the board KEY pins and the system interconnect, replacing a plain input PIO.

Parameters:
- WIDTH, 4, number of button inputs, 1..32.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced state changes, minimum 1; 50000 is 1 ms at 50 MHz.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived width of the per-button counter; not for override.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous button pins.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. On reset, all registers clear to 0: sync stages, debounced state, counters, irqmask, edgecapture and readdata. irq is therefore 0 after reset.
- Synchroniser: a 2-flop chain per bit, in_port -> s1 -> s2. s2 reflects in_port 2 edges after it is sampled.
- Debounce (per bit i), evaluated each edge:
  - If s2[i] == deb[i], then cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, then deb[i] <= s2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Result: deb[i] toggles on the DEBOUNCE_CYCLES-th consecutive edge on which s2[i] differs from it. Any glitch back to equality restarts the count. Total latency from a stable in_port change is 2+DEBOUNCE_CYCLES edges.
  - The counter never wraps; its maximum value is DEBOUNCE_CYCLES-1.
- Edge capture:
  - edgecapture[i] is set on the same edge that deb[i] goes 0->1.
  - A 1->0 transition of deb[i] does not set edgecapture[i].
  - A bit stays set until it is cleared by software.
- Register map (word address):
  - 0 DATA: RO; deb[WIDTH-1:0].
  - 1 IRQMASK: RW; WIDTH bits.
  - 2 EDGECAPTURE: read returns the captured bits. Writing 1 to a bit clears it (write-1-to-clear); writing 0 leaves it unchanged.
  - 3 RAW: RO; s2[WIDTH-1:0].
  - Writes to addresses 0 and 3 are ignored.
  - Unused upper bits read as 0.
- Write: takes effect when chipselect && write, on that edge.
- Read:
  - readdata <= zero-extended mux(address) on every edge.
  - Latency is 1 cycle; reads have no side effects.
  - A read returns register values from before that edge's updates.
- Simultaneous set and clear of the same edgecapture bit: set wins, so the bit stays 1.
- irq = |(edgecapture & irqmask), computed combinationally from registers. irq rises in the cycle after the edge that sets edgecapture or that enables irqmask.
- Reset asserted mid-debounce: the count is abandoned and deb returns to 0. A button still held after reset re-qualifies after 2+DEBOUNCE_CYCLES edges and then produces a new capture.

Optional Feature:
- Macro: NIOS32_BUTTON_CTRL_ACTIVE_LOW_EN.
- Defined: in_port is inverted before s1, for active-low board keys. A pressed key (pin 0) reads 1 in DATA and RAW, and a press produces a capture.
- Undefined: in_port is used as-is; a pin at 1 means pressed.

Test Plan:
1. Reset, then read addresses 0..3 -> readdata = 0x0 for each, one cycle after address is presented; irq = 0.
2. DEBOUNCE_CYCLES=4, macro undefined. Drive in_port=4'b0001 and hold -> DATA bit0 = 1 exactly 6 edges later and EDGECAPTURE = 0x1 on the same edge; irq stays 0 because IRQMASK = 0.
3. DEBOUNCE_CYCLES=4. Pulse in_port[1] high for 3 edges, then low -> DATA and EDGECAPTURE remain 0x0. RAW shows 0x2 for 3 cycles.
4. Write IRQMASK=0xF, then press bit2 -> irq = 1 one cycle after EDGECAPTURE = 0x4. Write 0x4 to address 2 -> EDGECAPTURE = 0x0 and irq = 0 on the following cycle.
5. Write 0x1 to address 2 on the same edge that deb[0] rises -> EDGECAPTURE bit0 = 1 (set wins).
6. Hold in_port=0x8, assert reset for 2 cycles mid-count, then release -> deb = 0 during reset; DATA = 0x8 and EDGECAPTURE = 0x8 after 2+DEBOUNCE_CYCLES edges. With the macro defined, in_port=0x7 gives DATA = 0x8.
